// File: rtl/fen_board_loader.sv
// FEN string loader: turns ASCII FEN bytes into the packed board, castle mask,
// en-passant column and side to move. Only well-formed strings are committed.
module fen_board_loader #(
  parameter int PIECE_WIDTH = 4,
  parameter int SIDE_WIDTH  = PIECE_WIDTH*8,
  parameter int BOARD_WIDTH = SIDE_WIDTH*8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             char_in,
  input  logic                   char_valid,
  output logic                   char_ready,
  output logic [BOARD_WIDTH-1:0] board,
  output logic [3:0]             castle_mask,
  output logic [3:0]             en_passant_col,
  output logic                   white_to_move,
  output logic                   display,
  input  logic                   display_done,
  output logic                   fen_error,
  output logic [15:0]            fen_count
);

  localparam logic [PIECE_WIDTH-1:0] EMPTY_POSN   = PIECE_WIDTH'(0);
  localparam logic [PIECE_WIDTH-1:0] WHITE_PAWN   = PIECE_WIDTH'(1);
  localparam logic [PIECE_WIDTH-1:0] WHITE_KNIGHT = PIECE_WIDTH'(2);
  localparam logic [PIECE_WIDTH-1:0] WHITE_BISHOP = PIECE_WIDTH'(3);
  localparam logic [PIECE_WIDTH-1:0] WHITE_ROOK   = PIECE_WIDTH'(4);
  localparam logic [PIECE_WIDTH-1:0] WHITE_QUEEN  = PIECE_WIDTH'(5);
  localparam logic [PIECE_WIDTH-1:0] WHITE_KING   = PIECE_WIDTH'(6);
  localparam logic [PIECE_WIDTH-1:0] BLACK_PAWN   = PIECE_WIDTH'(9);
  localparam logic [PIECE_WIDTH-1:0] BLACK_KNIGHT = PIECE_WIDTH'(10);
  localparam logic [PIECE_WIDTH-1:0] BLACK_BISHOP = PIECE_WIDTH'(11);
  localparam logic [PIECE_WIDTH-1:0] BLACK_ROOK   = PIECE_WIDTH'(12);
  localparam logic [PIECE_WIDTH-1:0] BLACK_QUEEN  = PIECE_WIDTH'(13);
  localparam logic [PIECE_WIDTH-1:0] BLACK_KING   = PIECE_WIDTH'(14);

  localparam logic [SIDE_WIDTH-1:0]  EMPTY_ROW   = {8{EMPTY_POSN}};
  localparam logic [BOARD_WIDTH-1:0] EMPTY_BOARD = {8{EMPTY_ROW}};

  localparam logic [7:0] CH_NL = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_SP = 8'h20;

  typedef enum logic [3:0] {
    PLACE, SIDE, CASTLE, EP_FILE, EP_RANK, CLOCKS, ERR_SKIP, COMMIT, WAIT_DONE
  } state_t;

  state_t                   state_q;
  logic [2:0]               row_q;
  logic [3:0]               col_q;
  logic                     got_q;  // a token byte was taken since the last separator
  logic [BOARD_WIDTH-1:0]   work_board_q, board_q;
  logic [3:0]               work_castle_q, castle_q;
  logic [3:0]               work_ep_q, ep_q;
  logic                     work_wtm_q, wtm_q;
  logic                     ready_q, display_q, disp_pend_q, fen_error_q;
  logic [15:0]              fen_count_q;

  logic                     xfer, is_nl, is_sp, is_piece, is_digit18, is_digit09, is_file;
  logic                     parse_err, clear_work;
  logic [PIECE_WIDTH-1:0]   piece_code;
  logic [3:0]               castle_bit;
  logic [4:0]               col_sum;
  logic [5:0]               sq;

  assign xfer       = char_valid && ready_q && (char_in != CH_CR);
  assign is_nl      = (char_in == CH_NL);
  assign is_sp      = (char_in == CH_SP);
  assign is_digit18 = (char_in >= 8'h31) && (char_in <= 8'h38);
  assign is_digit09 = (char_in >= 8'h30) && (char_in <= 8'h39);
  assign is_file    = (char_in >= 8'h61) && (char_in <= 8'h68);
  assign col_sum    = {1'b0, col_q} + {1'b0, char_in[3:0]};
  assign sq         = {row_q, col_q[2:0]};

  always_comb begin
    is_piece   = 1'b1;
    piece_code = EMPTY_POSN;
    case (char_in)
      "P": piece_code = WHITE_PAWN;
      "N": piece_code = WHITE_KNIGHT;
      "B": piece_code = WHITE_BISHOP;
      "R": piece_code = WHITE_ROOK;
      "Q": piece_code = WHITE_QUEEN;
      "K": piece_code = WHITE_KING;
      "p": piece_code = BLACK_PAWN;
      "n": piece_code = BLACK_KNIGHT;
      "b": piece_code = BLACK_BISHOP;
      "r": piece_code = BLACK_ROOK;
      "q": piece_code = BLACK_QUEEN;
      "k": piece_code = BLACK_KING;
      default: is_piece = 1'b0;
    endcase
  end

  always_comb begin
    castle_bit = 4'b0000;
    case (char_in)
      "K": castle_bit = 4'b0001;
      "Q": castle_bit = 4'b0010;
      "k": castle_bit = 4'b0100;
      "q": castle_bit = 4'b1000;
      default: castle_bit = 4'b0000;
    endcase
  end

  always_comb begin
    parse_err = 1'b0;
    case (state_q)
      PLACE: begin
        if (is_piece)            parse_err = col_q[3];
        else if (is_digit18)     parse_err = (col_sum > 5'd8);
        else if (char_in == "/") parse_err = !(col_q == 4'd8 && row_q != 3'd0);
        else if (is_sp)          parse_err = !(col_q == 4'd8 && row_q == 3'd0);
        else                     parse_err = 1'b1;
      end
      SIDE: begin
        if (char_in == "w" || char_in == "b") parse_err = got_q;
        else if (is_sp)                       parse_err = !got_q;
        else                                  parse_err = 1'b1;
      end
      CASTLE: begin
        // '-' must stand alone; letters may not follow '-' or repeat
        if (char_in == "-")       parse_err = got_q;
        else if (castle_bit != 0) parse_err = (got_q && work_castle_q == 4'b0000) ||
                                              ((work_castle_q & castle_bit) != 4'b0000);
        else if (is_sp)           parse_err = !got_q;
        else                      parse_err = 1'b1;
      end
      EP_FILE: parse_err = got_q ? !(is_sp || is_nl) : !(char_in == "-" || is_file);
      EP_RANK: parse_err = got_q ? !(is_sp || is_nl) : !(char_in == "3" || char_in == "6");
      CLOCKS:  parse_err = !(is_digit09 || is_sp || is_nl);
      default: parse_err = 1'b0;
    endcase
  end

  assign clear_work = (xfer && is_nl && (parse_err || state_q == ERR_SKIP)) ||
                      (state_q == WAIT_DONE && display_done);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= PLACE;
      row_q         <= 3'd7;
      col_q         <= 4'd0;
      got_q         <= 1'b0;
      work_board_q  <= EMPTY_BOARD;
      work_castle_q <= 4'b0000;
      work_ep_q     <= 4'b0000;
      work_wtm_q    <= 1'b1;
      board_q       <= EMPTY_BOARD;
      castle_q      <= 4'b0000;
      ep_q          <= 4'b0000;
      wtm_q         <= 1'b1;
      ready_q       <= 1'b0;
      display_q     <= 1'b0;
      disp_pend_q   <= 1'b0;
      fen_error_q   <= 1'b0;
      fen_count_q   <= 16'd0;
    end else begin
      display_q <= 1'b0;
      if (state_q != COMMIT && state_q != WAIT_DONE) ready_q <= 1'b1;

      if (xfer && parse_err) begin
        fen_error_q <= 1'b1;
        got_q       <= 1'b0;
        state_q     <= ERR_SKIP;
      end else begin
        case (state_q)
          PLACE: if (xfer) begin
            if (is_piece) begin
              work_board_q[int'(sq)*PIECE_WIDTH +: PIECE_WIDTH] <= piece_code;
              col_q <= col_q + 4'd1;
            end else if (is_digit18) begin
              col_q <= col_sum[3:0];
            end else if (char_in == "/") begin
              row_q <= row_q - 3'd1;
              col_q <= 4'd0;
            end else begin
              state_q <= SIDE;
              got_q   <= 1'b0;
            end
          end
          SIDE: if (xfer) begin
            if (is_sp) begin
              state_q <= CASTLE;
              got_q   <= 1'b0;
            end else begin
              work_wtm_q <= (char_in == "w");
              got_q      <= 1'b1;
            end
          end
          CASTLE: if (xfer) begin
            if (is_sp) begin
              state_q <= EP_FILE;
              got_q   <= 1'b0;
            end else begin
              work_castle_q <= work_castle_q | castle_bit;
              got_q         <= 1'b1;
            end
          end
          EP_FILE, EP_RANK: if (xfer) begin
            if (!got_q) begin
              if (state_q == EP_RANK) begin
                got_q <= 1'b1;
              end else if (char_in == "-") begin
                work_ep_q <= 4'b0000;
                got_q     <= 1'b1;
              end else begin
                work_ep_q <= {1'b1, char_in[2:0] - 3'd1};
                state_q   <= EP_RANK;
              end
            end else if (is_sp) begin
              state_q <= CLOCKS;
            end else begin
              state_q <= COMMIT;
              ready_q <= 1'b0;
            end
          end
          CLOCKS: if (xfer && is_nl) begin
            state_q <= COMMIT;
            ready_q <= 1'b0;
          end
          COMMIT: begin
            board_q     <= work_board_q;
            castle_q    <= work_castle_q;
            ep_q        <= work_ep_q;
            wtm_q       <= work_wtm_q;
            fen_error_q <= 1'b0;
            fen_count_q <= fen_count_q + 16'd1;
            disp_pend_q <= 1'b1;
            state_q     <= WAIT_DONE;
          end
          WAIT_DONE: begin
            display_q   <= disp_pend_q;
            disp_pend_q <= 1'b0;
          end
          default: ;
        endcase
      end

      if (clear_work) begin
        state_q       <= PLACE;
        row_q         <= 3'd7;
        col_q         <= 4'd0;
        got_q         <= 1'b0;
        work_board_q  <= EMPTY_BOARD;
        work_castle_q <= 4'b0000;
        work_ep_q     <= 4'b0000;
        work_wtm_q    <= 1'b1;
        ready_q       <= 1'b1;
      end
    end
  end

  assign char_ready     = ready_q;
  assign board          = board_q;
  assign castle_mask    = castle_q;
  assign en_passant_col = ep_q;
  assign white_to_move  = wtm_q;
  assign display        = display_q;
  assign fen_error      = fen_error_q;
  assign fen_count      = fen_count_q;

endmodule

// File: tb/tb_fen_board_loader.sv
// Scoreboard bench for fen_board_loader: a string-level FEN model predicts each
// commit; a monitor checks every display pulse and drives display_done.
module tb_fen_board_loader;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   char_in = 8'h00;
  logic         char_valid = 1'b0;
  logic         char_ready;
  logic [255:0] board;
  logic [3:0]   castle_mask, en_passant_col;
  logic         white_to_move, display, fen_error;
  logic         display_done = 1'b0;
  logic [15:0]  fen_count;

  fen_board_loader dut (
    .clk(clk), .reset(reset), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .board(board), .castle_mask(castle_mask),
    .en_passant_col(en_passant_col), .white_to_move(white_to_move),
    .display(display), .display_done(display_done), .fen_error(fen_error),
    .fen_count(fen_count)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [255:0] b;
    logic [3:0]   cm;
    logic [3:0]   ep;
    logic         wtm;
    logic [15:0]  cnt;
    int           due;
  } exp_t;
  exp_t sb[$];

  logic [255:0] m_board = '0;
  logic [3:0]   m_cm = 4'd0, m_ep = 4'd0;
  logic         m_wtm = 1'b1;
  logic [15:0]  m_cnt = 16'd0;
  int           hold_next = -1;
  int           n_checks = 0, n_pass = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic bit piece_of(input byte ch, output logic [3:0] code);
    code = 4'h0;
    case (ch)
      "P": code = 4'h1;  "N": code = 4'h2;  "B": code = 4'h3;
      "R": code = 4'h4;  "Q": code = 4'h5;  "K": code = 4'h6;
      "p": code = 4'h9;  "n": code = 4'hA;  "b": code = 4'hB;
      "r": code = 4'hC;  "q": code = 4'hD;  "k": code = 4'hE;
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  function automatic void split(input string s, input byte sep, output string parts[$]);
    string cur = "";
    parts.delete();
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == sep) begin
        parts.push_back(cur);
        cur = "";
      end else cur = $sformatf("%s%c", cur, s[i]);
    end
    parts.push_back(cur);
  endfunction

  // Field-by-field FEN reference: returns 1 and the decoded position if the string is legal.
  function automatic bit model_parse(input string s, output logic [255:0] b,
                                     output logic [3:0] cm, output logic [3:0] ep,
                                     output logic wtm);
    string t = "", f[$], ranks[$], rk, e;
    int nl = 0, c;
    logic [3:0] code;
    b = '0; cm = 4'd0; ep = 4'd0; wtm = 1'b1;
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == 8'h0D) continue;
      if (s[i] == 8'h0A) nl++;
      t = $sformatf("%s%c", t, s[i]);
    end
    if (nl != 1 || t[t.len()-1] != 8'h0A) return 1'b0;
    t = t.substr(0, t.len()-2);
    split(t, " ", f);
    if (f.size() < 4) return 1'b0;
    split(f[0], "/", ranks);
    if (ranks.size() != 8) return 1'b0;
    for (int k = 0; k < 8; k++) begin
      rk = ranks[k];
      c = 0;
      for (int i = 0; i < rk.len(); i++) begin
        if (rk[i] >= "1" && rk[i] <= "8") c += int'(rk[i]) - 48;
        else if (piece_of(rk[i], code)) begin
          if (c < 8) b[((7-k)*8 + c)*4 +: 4] = code;
          c++;
        end else return 1'b0;
      end
      if (c != 8) return 1'b0;
    end
    if (f[1] == "w") wtm = 1'b1;
    else if (f[1] == "b") wtm = 1'b0;
    else return 1'b0;
    e = f[2];
    if (e != "-") begin
      if (e.len() == 0) return 1'b0;
      for (int i = 0; i < e.len(); i++) begin
        int bi;
        case (e[i])
          "K": bi = 0;  "Q": bi = 1;  "k": bi = 2;  "q": bi = 3;
          default: return 1'b0;
        endcase
        if (cm[bi]) return 1'b0;
        cm[bi] = 1'b1;
      end
    end
    e = f[3];
    if (e != "-") begin
      if (e.len() != 2 || e[0] < "a" || e[0] > "h" || !(e[1] == "3" || e[1] == "6")) return 1'b0;
      ep = {1'b1, 3'(int'(e[0]) - 97)};
    end
    for (int j = 4; j < f.size(); j++) begin
      e = f[j];
      for (int i = 0; i < e.len(); i++)
        if (e[i] < "0" || e[i] > "9") return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic string gen_fen();
    string s = "", pcs = "PNBRQKpnbrqk", cs = "KQkq", plc;
    int run;
    for (int r = 7; r >= 0; r--) begin
      run = 0;
      for (int c = 0; c < 8; c++) begin
        if ($urandom_range(2) == 0) begin
          if (run > 0) s = $sformatf("%s%0d", s, run);
          run = 0;
          s = $sformatf("%s%c", s, pcs[$urandom_range(11)]);
        end else run++;
      end
      if (run > 0) s = $sformatf("%s%0d", s, run);
      if (r > 0) s = {s, "/"};
    end
    plc = s;
    s = {s, ($urandom_range(1) == 1) ? " w " : " b "};
    run = $urandom_range(15);
    if (run == 0) s = {s, "-"};
    else for (int i = 0; i < 4; i++) if (run[i]) s = $sformatf("%s%c", s, cs[i]);
    if ($urandom_range(1) == 1) s = {s, " -"};
    else s = $sformatf("%s %c%c", s, 8'h61 + $urandom_range(7), ($urandom_range(1) == 1) ? "3" : "6");
    if ($urandom_range(2) != 0) s = $sformatf("%s %0d %0d", s, $urandom_range(99), $urandom_range(200));
    if ($urandom_range(3) == 0) s = {s, "\r"};
    s = {s, "\n"};
    case ($urandom_range(7))
      0: s.putc($urandom_range(plc.len()-1), "x");
      1: s = {"p", s};
      2: s.putc(plc.len()+1, "x");
      default: ;
    endcase
    return s;
  endfunction

  task automatic send_byte(input byte bch);
    int n = 0;
    char_in = bch;
    char_valid = 1'b1;
    while (!char_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!char_ready) begin
      n_checks++;
      $display("FAIL handshake_timeout: char_ready stuck at 0 for byte %h", bch);
    end else @(posedge clk);
    @(negedge clk);
    char_valid = 1'b0;
  endtask

  task automatic send_fen(input string s);
    logic [255:0] b;
    logic [3:0] cm, ep;
    logic wtm;
    bit ok;
    exp_t x;
    ok = model_parse(s, b, cm, ep, wtm);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    if (ok) begin
      m_board = b; m_cm = cm; m_ep = ep; m_wtm = wtm; m_cnt = m_cnt + 16'd1;
      x.b = b; x.cm = cm; x.ep = ep; x.wtm = wtm; x.cnt = m_cnt; x.due = cyc + 2;
      sb.push_back(x);
    end else begin
      check("err_flag", fen_error, 1);
      check("err_board_kept", board, m_board);
      check("err_castle_kept", castle_mask, m_cm);
      check("err_ep_kept", en_passant_col, m_ep);
      check("err_wtm_kept", white_to_move, m_wtm);
      check("err_count_kept", fen_count, m_cnt);
      check("err_ready_back", char_ready, 1);
    end
  endtask

  // Monitor: scores each display pulse and answers it with display_done.
  initial begin
    bit active = 0, ready_due = 0;
    int wait_n = 0;
    exp_t x;
    forever begin
      @(negedge clk);
      display_done = 1'b0;
      if (!reset) begin
        active = 0;
        ready_due = 0;
      end else begin
        if (ready_due) begin
          check("ready_after_done", char_ready, 1);
          ready_due = 0;
        end
        if (active) begin
          check("ready_low_wait", char_ready, 0);
          if (wait_n == 0) begin
            display_done = 1'b1;
            active = 0;
            ready_due = 1;
          end else wait_n--;
        end
        if (display) begin
          if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_display: got display=1 expected no pulse at cycle %0d", cyc);
          end else begin
            x = sb.pop_front();
            check("board", board, x.b);
            check("castle_mask", castle_mask, x.cm);
            check("en_passant_col", en_passant_col, x.ep);
            check("white_to_move", white_to_move, x.wtm);
            check("fen_count", fen_count, x.cnt);
            check("fen_error_clear", fen_error, 0);
            check("display_latency", cyc, x.due);
          end
          active = 1;
          wait_n = (hold_next >= 0) ? hold_next : int'($urandom_range(5));
          hold_next = -1;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string start_fen;
    start_fen = "rnbqkbnr/pppppppp/8/8/8/8/PPPPPPPP/RNBQKBNR w KQkq - 0 1\n";
    #3 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_board", board, 256'd0);
    check("rst_castle", castle_mask, 0);
    check("rst_ep", en_passant_col, 0);
    check("rst_wtm", white_to_move, 1);
    check("rst_display", display, 0);
    check("rst_error", fen_error, 0);
    check("rst_count", fen_count, 0);
    check("rst_ready", char_ready, 0);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_rst", char_ready, 1);

    send_fen(start_fen);
    send_fen("4k3/8/8/3pP3/8/8/8/4K3 w - d6 0 3\n");
    send_fen("ppppppppp/8/8/8/8/8/8/8 w - - 0 1\n");
    hold_next = 20;
    send_fen("8/8/8/8/8/8/8/K6k b - - 0 1\n");
    send_fen("r3k2r/8/8/8/8/8/8/R3K2R b Kq - 5 40\r\n");
    send_fen("8/8/8/8/8/8/8/8 w KK - 0 1\n");
    send_fen("rnbqkbnr/pppppppp/8/8/4P3/8/PPPP1PPP/RNBQKBNR b KQkq e3\n");

    for (int i = 0; i < 30; i++) send_fen(gen_fen());

    for (int i = 0; i < 10; i++) send_byte(start_fen[i]);
    reset = 1'b0;
    #1;
    check("midrst_board", board, 256'd0);
    check("midrst_castle", castle_mask, 0);
    check("midrst_ep", en_passant_col, 0);
    check("midrst_wtm", white_to_move, 1);
    check("midrst_count", fen_count, 0);
    check("midrst_error", fen_error, 0);
    check("midrst_ready", char_ready, 0);
    m_board = '0; m_cm = 4'd0; m_ep = 4'd0; m_wtm = 1'b1; m_cnt = 16'd0;
    @(negedge clk);
    reset = 1'b1;
    send_fen(start_fen);
    send_fen(gen_fen());

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
